// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared widths and state encoding for the RAM burst master
package ram_pkg;

    localparam int RAM_ADR_W  = 8;
    localparam int RAM_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/ram_beat_counter.sv
// rtl/ram_beat_counter.sv - burst address generator and remaining-beat counter
module ram_beat_counter #(
    parameter int ADR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [ADR_W-1:0] load_adr,
    input  logic [ADR_W-1:0] load_len,
    output logic [ADR_W-1:0] adr,
    output logic             last,
    output logic             zero
);

    localparam logic [ADR_W-1:0] ADR_ONE = {{(ADR_W-1){1'b0}}, 1'b1};
    localparam logic [ADR_W:0]   CNT_ONE = {{ADR_W{1'b0}}, 1'b1};

    logic [ADR_W-1:0] adr_q, adr_d;
    // one extra bit so that a full 2^ADR_W-beat burst is representable
    logic [ADR_W:0]   cnt_q, cnt_d;

    // load a new burst, or advance one beat with natural address wrap
    always_comb begin
        adr_d = adr_q;
        cnt_d = cnt_q;
        if (load) begin
            adr_d = load_adr;
            cnt_d = {1'b0, load_len} + CNT_ONE;
        end else if (step && (cnt_q != '0)) begin
            adr_d = adr_q + ADR_ONE;
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    // address and count registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adr_q <= '0;
            cnt_q <= '0;
        end else begin
            adr_q <= adr_d;
            cnt_q <= cnt_d;
        end
    end

    assign adr  = adr_q;
    assign last = (cnt_q == CNT_ONE);
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/ram_burst_master.sv
// rtl/ram_burst_master.sv - command-driven burst read/write master for a synchronous RAM
module ram_burst_master
    import ram_pkg::*;
#(
    parameter int ADR_W  = RAM_ADR_W,
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              clk,
    input  logic              start,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADR_W-1:0]  cmd_adr,
    input  logic [ADR_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              done,
    output logic              ram_we,
    output logic [ADR_W-1:0]  ram_adr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    state_t           state_q, state_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             wr_ready_q, wr_ready_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_last_q, rd_last_d;
    logic             done_q, done_d;

    logic             cnt_load;
    logic             cnt_step;
    logic [ADR_W-1:0] cur_adr;
    logic             cnt_last;
    logic             cnt_zero;
    logic             beat_wr;

    ram_beat_counter #(
        .ADR_W (ADR_W)
    ) u_beat_counter (
        .clk      (clk),
        .rst      (start),
        .load     (cnt_load),
        .step     (cnt_step),
        .load_adr (cmd_adr),
        .load_len (cmd_len),
        .adr      (cur_adr),
        .last     (cnt_last),
        .zero     (cnt_zero)
    );

    // a write beat lands on the RAM in the same cycle it is offered
    assign beat_wr = (state_q == ST_WRITE) && wr_valid && !cnt_zero;

    // next-state and registered-output decode
    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    cnt_load = 1'b1;
                    state_d  = cmd_wr ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                if (beat_wr) begin
                    cnt_step = 1'b1;
                    if (cnt_last) state_d = ST_DONE;
                end
            end
            ST_READ: begin
                cnt_step = !cnt_zero;
                if (cnt_last || cnt_zero) state_d = ST_DRAIN;
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        cmd_ready_d = (state_d == ST_IDLE);
        wr_ready_d  = (state_d == ST_WRITE);
        // RAM data for an address issued now appears next cycle
        rd_valid_d  = (state_q == ST_READ);
        rd_last_d   = (state_q == ST_READ) && (state_d == ST_DRAIN);
        done_d      = (state_d == ST_DONE);
    end

    // state and registered handshake/status outputs
    always_ff @(posedge clk or posedge start) begin
        if (start) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            wr_ready_q  <= wr_ready_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            done_q      <= done_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign wr_ready  = wr_ready_q;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;
    assign done      = done_q;
    assign rd_data   = rd_valid_q ? ram_dout : '0;
    assign ram_we    = beat_wr;
    assign ram_din   = beat_wr ? wr_data : '0;
    assign ram_adr   = ((state_q == ST_WRITE) || (state_q == ST_READ)) ? cur_adr : '0;

endmodule

// File: tb/tb_ram_burst_master.sv
// tb/tb_ram_burst_master.sv - randomized directed bench with RAM model and reference memory
module tb_ram_burst_master;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          start = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_wr = 1'b0;
    logic [AW-1:0] cmd_adr = '0;
    logic [AW-1:0] cmd_len = '0;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] ram_dout;
    logic          cmd_ready, wr_ready, rd_valid, rd_last, done, ram_we;
    logic [DW-1:0] rd_data, ram_din;
    logic [AW-1:0] ram_adr;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] tb_mem   [256];
    logic [DW-1:0] ref_mem  [256];
    logic [DW-1:0] seed_mem [256];
    logic [DW-1:0] wdata    [256];
    logic          mem_load = 1'b1;

    always #5 clk = ~clk;

    ram_burst_master #(.ADR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .start     (start),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr    (cmd_wr),
        .cmd_adr   (cmd_adr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .done      (done),
        .ram_we    (ram_we),
        .ram_adr   (ram_adr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    // synchronous RAM: write on edge, read data one clock after address
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= seed_mem[i];
        end else if (ram_we) begin
            tb_mem[ram_adr] <= ram_din;
        end
        ram_dout <= tb_mem[ram_adr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic wr, input logic [7:0] adr, input logic [7:0] len);
        int n;
        n = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_wr = wr; cmd_adr = adr; cmd_len = len;
        #1;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("cmd_ready", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // mode 0: wr_valid always high, 1: toggling starting low, 2: random
    task automatic do_write(input logic [7:0] adr, input logic [7:0] len, input int mode);
        int n, beat, cyc;
        logic [7:0] a;
        logic v;
        n = int'(len) + 1; beat = 0; cyc = 0; a = adr;
        send_cmd(1'b1, adr, len);
        while (beat < n && cyc < 4 * n + 20) begin
            @(negedge clk);
            case (mode)
                0:       v = 1'b1;
                1:       v = cyc[0];
                default: v = 1'($urandom_range(0, 1));
            endcase
            wr_valid = v; wr_data = wdata[beat];
            #1;
            chk("wr_ready", wr_ready, 1);
            chk("wr_ram_we", ram_we, v);
            if (v) begin
                chk("wr_adr", ram_adr, a);
                chk("wr_din", ram_din, wdata[beat]);
                ref_mem[a] = wdata[beat];
                a++; beat++;
            end
            cyc++;
        end
        chk("wr_beats", beat, n);
        @(negedge clk); wr_valid = 1'b0; #1;
        chk("wr_done", done, 1);
        chk("wr_done_we", ram_we, 0);
        chk("wr_done_cmd_ready", cmd_ready, 0);
        chk("wr_done_wr_ready", wr_ready, 0);
        @(negedge clk); #1;
        chk("wr_idle_done", done, 0);
        chk("wr_idle_cmd_ready", cmd_ready, 1);
    endtask

    task automatic do_read(input logic [7:0] adr, input logic [7:0] len);
        int n, beat, cyc;
        bit seen_done;
        logic [7:0] a, ea;
        n = int'(len) + 1; beat = 0; cyc = 0; seen_done = 1'b0; a = adr;
        send_cmd(1'b0, adr, len);
        while (!seen_done && cyc < n + 10) begin
            @(negedge clk); #1; cyc++;
            chk("rd_we", ram_we, 0);
            if (cyc <= n) begin
                ea = adr + 8'(cyc - 1);
                chk("rd_adr", ram_adr, ea);
            end
            chk("rd_valid", rd_valid, (cyc >= 2 && cyc <= n + 1));
            if (rd_valid) begin
                chk("rd_data", rd_data, ref_mem[a]);
                chk("rd_last", rd_last, (beat == n - 1));
                a++; beat++;
            end
            if (done) begin
                chk("rd_done_cycle", cyc, n + 2);
                seen_done = 1'b1;
            end
        end
        chk("rd_beats", beat, n);
        chk("rd_done_seen", seen_done, 1);
        @(negedge clk); #1;
        chk("rd_idle_cmd_ready", cmd_ready, 1);
        chk("rd_idle_done", done, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ra, rl;
        for (int i = 0; i < 256; i++) begin
            seed_mem[i] = $urandom;
            ref_mem[i]  = seed_mem[i];
        end

        // reset behaviour
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_ram_adr", ram_adr, 0);
        @(posedge clk); @(posedge clk); #1;
        mem_load = 1'b0;
        chk("rst_hold_cmd_ready", cmd_ready, 0);
        @(negedge clk); start = 1'b0; #1;
        chk("release_cmd_ready_pre_edge", cmd_ready, 0);
        @(posedge clk); #1;
        chk("release_cmd_ready", cmd_ready, 1);

        // four-beat write then readback
        wdata[0] = 50; wdata[1] = 2; wdata[2] = 7; wdata[3] = 9;
        do_write(8'd1, 8'd3, 0);
        chk("mem1", tb_mem[1], 50);
        chk("mem2", tb_mem[2], 2);
        chk("mem3", tb_mem[3], 7);
        chk("mem4", tb_mem[4], 9);
        do_read(8'd1, 8'd3);

        // wrapping write with toggling wr_valid
        for (int i = 0; i < 256; i++) wdata[i] = $urandom;
        do_write(8'd254, 8'd2, 1);
        chk("wrap_mem254", tb_mem[254], wdata[0]);
        chk("wrap_mem255", tb_mem[255], wdata[1]);
        chk("wrap_mem0", tb_mem[0], wdata[2]);
        chk("wrap_mem1_kept", tb_mem[1], 50);

        // single-beat bursts
        for (int i = 0; i < 256; i++) wdata[i] = $urandom;
        do_write(8'h40, 8'd0, 2);
        do_read(8'h40, 8'd0);

        // full 256-beat read
        do_read(8'd0, 8'd255);

        // abort during the second beat of a four-beat write
        for (int i = 0; i < 256; i++) wdata[i] = $urandom;
        send_cmd(1'b1, 8'd2, 8'd3);
        @(negedge clk); wr_valid = 1'b1; wr_data = wdata[0]; #1;
        chk("abort_beat1_we", ram_we, 1);
        chk("abort_beat1_adr", ram_adr, 2);
        ref_mem[2] = wdata[0];
        @(negedge clk); wr_data = wdata[1]; #1;
        chk("abort_beat2_adr", ram_adr, 3);
        start = 1'b1; #1;
        chk("abort_we", ram_we, 0);
        chk("abort_wr_ready", wr_ready, 0);
        chk("abort_done", done, 0);
        chk("abort_cmd_ready", cmd_ready, 0);
        @(negedge clk); #1;
        chk("abort_hold_we", ram_we, 0);
        start = 1'b0; #1;
        chk("abort_release_cmd_ready", cmd_ready, 0);
        @(posedge clk); #1;
        chk("abort_cmd_ready_after", cmd_ready, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            chk("abort_idle_we", ram_we, 0);
            chk("abort_idle_done", done, 0);
            chk("abort_idle_rd_valid", rd_valid, 0);
        end
        wr_valid = 1'b0;
        chk("abort_mem2", tb_mem[2], wdata[0]);
        chk("abort_mem3", tb_mem[3], ref_mem[3]);
        chk("abort_mem4", tb_mem[4], ref_mem[4]);

        // command held valid across a burst is taken only once back in IDLE
        for (int i = 0; i < 256; i++) wdata[i] = $urandom;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_adr = 8'h20; cmd_len = 8'd1; #1;
        chk("hold_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_wr = 1'b0; cmd_adr = 8'h20; cmd_len = 8'd0;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk); wr_valid = 1'b1; wr_data = wdata[b]; #1;
            chk("hold_busy_cmd_ready", cmd_ready, 0);
            chk("hold_we", ram_we, 1);
            chk("hold_adr", ram_adr, 8'h20 + 8'(b));
            ref_mem[8'h20 + 8'(b)] = wdata[b];
        end
        @(negedge clk); wr_valid = 1'b0; #1;
        chk("hold_done", done, 1);
        chk("hold_done_cmd_ready", cmd_ready, 0);
        @(negedge clk); #1;
        chk("hold_idle_cmd_ready", cmd_ready, 1);
        chk("hold_idle_adr", ram_adr, 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk); #1;
        chk("hold_read_adr", ram_adr, 8'h20);
        chk("hold_read_we", ram_we, 0);
        chk("hold_read_rd_valid", rd_valid, 0);
        @(negedge clk); #1;
        chk("hold_drain_rd_valid", rd_valid, 1);
        chk("hold_drain_rd_data", rd_data, ref_mem[8'h20]);
        chk("hold_drain_rd_last", rd_last, 1);
        @(negedge clk); #1;
        chk("hold_read_done", done, 1);
        @(negedge clk); #1;
        chk("hold_final_cmd_ready", cmd_ready, 1);
        chk("hold_final_done", done, 0);

        // random bursts written then read back
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 256; i++) wdata[i] = $urandom;
            ra = 8'($urandom);
            rl = 8'($urandom_range(0, 15));
            do_write(ra, rl, 2);
            do_read(ra, rl);
        end

        // whole-memory comparison against the reference
        for (int i = 0; i < 256; i++) chk("final_mem", tb_mem[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_burst_master.md
RAM_BURST_MASTER -- requirements
Module: ram_burst_master

Interface
REQ-001 Parameter ADR_W, default 8, RAM address width.
REQ-002 Parameter DATA_W, default 32, RAM word width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 start  input  1  reset, asynchronous, active-high.
REQ-005 cmd_valid  input  1  burst command offered.
REQ-006 cmd_ready  output  1  block accepts command (high only in IDLE).
REQ-007 cmd_wr  input  1  1 = write burst, 0 = read burst.
REQ-008 cmd_adr  input  ADR_W  first RAM address of burst.
REQ-009 cmd_len  input  ADR_W  beats minus one (0 -> 1 beat, 255 -> 256 beats).
REQ-010 wr_valid  input  1  write data beat offered.
REQ-011 wr_ready  output  1  write beat accepted this cycle.
REQ-012 wr_data  input  DATA_W  write data.
REQ-013 rd_valid  output  1  rd_data valid this cycle (no backpressure).
REQ-014 rd_data  output  DATA_W  read data.
REQ-015 rd_last  output  1  marks final read beat.
REQ-016 done  output  1  one-cycle pulse at burst completion.
REQ-017 ram_we  output  1  RAM write enable.
REQ-018 ram_adr  output  ADR_W  RAM address.
REQ-019 ram_din  output  DATA_W  RAM write data.
REQ-020 ram_dout  input  DATA_W  RAM read data, valid one clk after ram_adr is sampled.

Function
REQ-021 States SHALL be IDLE, WRITE, READ, DRAIN, DONE.
REQ-022 IDLE: cmd_ready=1; cmd_valid&cmd_ready latches cmd_wr/adr/len, next state WRITE (cmd_wr=1) or READ (cmd_wr=0).
REQ-023 WRITE: wr_ready=1; each cycle with wr_valid=1 drives ram_we=1, ram_adr=current address, ram_din=wr_data in the same cycle; cycles with wr_valid=0 drive ram_we=0 and hold address.
REQ-024 READ: one address issued per cycle on ram_adr with ram_we=0; rd_valid/rd_data presented exactly one cycle after each address (ram_dout registered to rd_data path without extra stage).
REQ-025 After the last read address, state SHALL be DRAIN for one cycle to output the final beat with rd_last=1.
REQ-026 Address SHALL increment by 1 per accepted beat, modulo 2^ADR_W (255 wraps to 0).
REQ-027 Beat counter SHALL be ADR_W+1 bits wide so a 256-beat burst is counted exactly.
REQ-028 WRITE exits to DONE on the cycle the final beat is accepted; DRAIN exits to DONE.
REQ-029 DONE: done=1 for one cycle, then IDLE; cmd_ready=0 in DONE.
REQ-030 ram_we SHALL never be 1 outside WRITE; wr_ready SHALL be 0 outside WRITE.
REQ-031 cmd_valid outside IDLE SHALL be ignored (command not consumed).
REQ-032 Burst of 1 beat (cmd_len=0): write = one beat then DONE; read = READ one cycle, DRAIN, DONE.

Reset
REQ-033 start=1 SHALL immediately force IDLE and all outputs to 0 except cmd_ready=0 while start is high; cmd_ready=1 from first clk edge after release.
REQ-034 start asserted mid-burst SHALL abort the burst: no further ram_we, no rd_valid, no done pulse.
REQ-035 Internal address and beat counters reset to 0.

Structure
REQ-036 Package ram_pkg SHALL hold ADR_W, DATA_W defaults and the state encoding, shared with the ram block.
REQ-037 One sub-module ram_beat_counter (load, decrement, zero flag, address increment with wrap) SHALL be instantiated.

Verification
REQ-038 Write cmd_adr=1, cmd_len=3, data 50,2,7,9 with wr_valid always 1 -> RAM addr 1..4 holds 50,2,7,9; done one cycle after 4th beat.
REQ-039 Read cmd_adr=1, cmd_len=3 after REQ-038 -> rd_data 50,2,7,9 on four consecutive cycles, rd_last on 9, then done.
REQ-040 Write cmd_adr=254, cmd_len=2, wr_valid toggling every cycle -> writes to 254,255,0 only on wr_valid cycles; ram_we low otherwise.
REQ-041 Read cmd_adr=0, cmd_len=255 -> exactly 256 rd_valid beats, addresses 0..255, rd_last on the 256th.
REQ-042 start pulsed during 2nd beat of a 4-beat write -> ram_we=0 immediately, no done, cmd_ready=1 after release, addresses 3..4 unchanged.
REQ-043 cmd_valid held high during a burst -> command accepted only once back in IDLE.
